// File: rtl/alu_exec_seq.sv
// alu_exec_seq
// ------------
// Execution-side consumer of the 4-bit ALU control code. An operation
// (op code + two operands) is accepted over an input valid/ready handshake,
// computed, and the result plus flags is held on an output valid/ready
// handshake until the downstream writeback/branch stage takes it.
//
// Optional feature macro: ALU_EXEC_MUL_EN
//   defined   -> alu_op 4'b1000 is an unsigned iterative shift-add multiply
//                (one multiplier bit per cycle, BUSY state, counter, accumulator)
//   undefined -> 4'b1000 is treated as an unsupported op, no multiplier built
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   in_valid   in   operands and op code valid
//   in_ready   out  block can accept an operation (IDLE and not in reset)
//   alu_op     in   4-bit op code
//   src_a      in   operand A (WIDTH)
//   src_b      in   operand B (WIDTH)
//   out_valid  out  result and flags valid
//   out_ready  in   downstream accepts the result
//   result     out  operation result (WIDTH)
//   zero       out  result == 0
//   overflow   out  signed overflow (ADD/SUB), upper product nonzero (MUL)
//   illegal_op out  alu_op was not a supported code
//   dbg_state  out  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; a valid producer holds its data stable until
// that edge. An accepted op cannot overlap the consumption of the previous
// result, so peak throughput is one op every two cycles.

module alu_exec_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CW     = $clog2(WIDTH) + 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             illegal_q;

  // Single-cycle ALU results for the operands currently presented.
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_ovf_d;
  logic             alu_ill_d;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_bit;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    sum       = src_a + src_b;
    diff      = src_a - src_b;
    slt_bit   = ($signed(src_a) < $signed(src_b));
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    alu_ill_d = 1'b0;
    case (alu_op)
      OP_AND: alu_res_d = src_a & src_b;
      OP_OR:  alu_res_d = src_a | src_b;
      OP_ADD: begin
        alu_res_d = sum;
        // Same-sign operands producing a result of the other sign.
        alu_ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                    (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff;
        alu_ovf_d = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                    (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR: alu_res_d = ~(src_a | src_b);
`ifdef ALU_EXEC_MUL_EN
      OP_MUL: alu_res_d = '0;  // produced by the iterative datapath
`endif
      default: alu_ill_d = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  // Shift-add multiplier: prod_q = {partial sum, remaining multiplier bits}.
  // Each step adds the multiplicand to the upper half when the current
  // multiplier LSB is set, then shifts the whole register right by one.
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_step;

  always_comb begin
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step = {step_sum, prod_q[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
`ifdef ALU_EXEC_MUL_EN
            if (alu_op == OP_MUL) begin
              state_q <= ST_BUSY;
              mcand_q <= src_a;
              prod_q  <= {{WIDTH{1'b0}}, src_b};
              cnt_q   <= '0;
            end else begin
`endif
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res_d;
              zero_q      <= (alu_res_d == '0);
              overflow_q  <= alu_ovf_d;
              illegal_q   <= alu_ill_d;
`ifdef ALU_EXEC_MUL_EN
            end
`endif
          end
        end
`ifdef ALU_EXEC_MUL_EN
        ST_BUSY: begin
          // WIDTH iteration steps, then one edge to publish the product.
          if (cnt_q == CW'(WIDTH)) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= prod_q[WIDTH-1:0];
            zero_q      <= (prod_q[WIDTH-1:0] == '0);
            overflow_q  <= (prod_q[2*WIDTH-1:WIDTH] != '0);
            illegal_q   <= 1'b0;
          end else begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
`endif
        ST_DONE: begin
          // Outputs hold until taken; afterwards they keep their last values.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = reset_n && (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign overflow   = overflow_q;
  assign illegal_op = illegal_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
module tb_alu_exec_seq;

  localparam int WIDTH = 32;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal_op;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  alu_exec_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .illegal_op (illegal_op),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present an op, wait (bounded) for in_ready, let one edge accept it,
  // then wait (bounded) for out_valid and check latency and outputs.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input logic exp_ovf,
                        input logic exp_ill, input int exp_lat);
    int n;
    logic [WIDTH-1:0] exp_r;
    exp_q.push_back(exp_res);
    @(negedge clk);
    alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    check({tag, "_latency"}, n, exp_lat);
    exp_r = exp_q.pop_front();
    check({tag, "_result"}, result, exp_r);
    check({tag, "_zero"}, zero, (exp_r == '0));
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_illegal"}, illegal_op, exp_ill);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_consumed_valid"}, out_valid, 1'b0);
    check({tag, "_consumed_ready"}, in_ready, 1'b1);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rst_valid"}, out_valid, 1'b0);
    check({tag, "_rst_result"}, result, 32'h0);
    check({tag, "_rst_ovf"}, overflow, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check({tag, "_rst_in_ready"}, in_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'h0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_result", result, 32'h0);
    check("reset_zero", zero, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_illegal", illegal_op, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1'b1);

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0, 1);
    consume("add_ovf");
    run_op("sub_zero", 4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1);
    consume("sub_zero");
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    consume("sub_ovf");
    run_op("slt_true", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1);
    consume("slt_true");
    run_op("slt_false", 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1);
    consume("slt_false");
    run_op("or", 4'b0001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0, 1);
    consume("or");

    // Backpressure: result must hold, in_ready low, new requests ignored.
    run_op("and_bp", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1);
    in_valid = 1'b1; alu_op = 4'b0010; src_a = 32'h1; src_b = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_result_hold", result, 32'hF000_F000);
      check("bp_valid_hold", out_valid, 1'b1);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    consume("and_bp");
    check("bp_stale_result_kept", result, 32'hF000_F000);

    run_op("illegal", 4'b0011, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1, 1);
    consume("illegal");
    run_op("nor", 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    consume("nor");

`ifdef ALU_EXEC_MUL_EN
    run_op("mul_ovf", 4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0, 33);
    consume("mul_ovf");
    run_op("mul_small", 4'b1000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 33);
    consume("mul_small");
    // Reset while the multiplier is iterating.
    @(negedge clk);
    alu_op = 4'b1000; src_a = 32'd3; src_b = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    pulse_reset("busy");
    run_op("after_busy_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);
    consume("after_busy_rst");
`else
    run_op("mul_disabled", 4'b1000, 32'd6, 32'd7, 32'h0, 1'b0, 1'b1, 1);
    consume("mul_disabled");
`endif

    // Reset while a result waits in DONE.
    run_op("pre_done_rst", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
    pulse_reset("done");
    run_op("after_done_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);
    consume("after_done_rst");

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
